// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared types and constants for the UART transmit scheduler
// Optional feature macro: UART_TX_PARITY_EN (adds an even parity bit, 8E1 framing)
package uart_tx_pkg;

    // Requester identities, also the encoding of the arbiter's last_grant register.
    localparam logic SRC_HPS = 1'b0;
    localparam logic SRC_LOC = 1'b1;

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ser_state_t;

    localparam int FRAME_BITS = 11;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } ser_state_t;

    localparam int FRAME_BITS = 10;
`endif

    // Nearest-integer divisor keeps the bit period within half a clock of ideal.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_tx_sched_if.sv
// rtl/uart_tx_sched_if.sv - two-requester byte handshake bundle for uart_tx_sched
// master: requester side (drives data/valid), slave: scheduler side (drives ready)
interface uart_tx_sched_if;

    logic [7:0] hps_data;
    logic       hps_valid;
    logic       hps_ready;
    logic [7:0] loc_data;
    logic       loc_valid;
    logic       loc_ready;

    modport master (
        output hps_data, hps_valid, loc_data, loc_valid,
        input  hps_ready, loc_ready
    );

    modport slave (
        input  hps_data, hps_valid, loc_data, loc_valid,
        output hps_ready, loc_ready
    );

endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - 8N1 (or 8E1 with UART_TX_PARITY_EN) frame serialiser
// Ports: clk, rst_n; fifo_empty/fifo_data in, fifo_pop out (combinational);
//        busy_next (serialiser active after the coming edge); uart_tx, frame_done registered.
module uart_tx_serializer
    import uart_tx_pkg::*;
#(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       fifo_empty,
    input  logic [7:0] fifo_data,
    output logic       fifo_pop,
    output logic       busy_next,
    output logic       uart_tx,
    output logic       frame_done
);

    localparam int               CNT_W      = $clog2(BAUD_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_PENULT = CNT_W'(BAUD_DIV - 2);

    ser_state_t       state;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_cnt;
    logic [7:0]       shift_reg;
    logic             bit_end;
`ifdef UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    assign bit_end = (baud_cnt == CNT_LAST);

    // Popping on the edge that ends a stop bit starts the next frame with no idle gap.
    assign fifo_pop  = !fifo_empty && ((state == ST_IDLE) || (state == ST_STOP && bit_end));
    assign busy_next = fifo_pop || ((state != ST_IDLE) && !(state == ST_STOP && bit_end));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            uart_tx    <= 1'b1;
            frame_done <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            // Raised one cycle early so the registered pulse covers the last stop cycle.
            frame_done <= (state == ST_STOP) && (baud_cnt == CNT_PENULT);
            if (fifo_pop) begin
                state     <= ST_START;
                baud_cnt  <= '0;
                bit_cnt   <= '0;
                shift_reg <= fifo_data;
                uart_tx   <= 1'b0;
`ifdef UART_TX_PARITY_EN
                parity_bit <= ^fifo_data;
`endif
            end else begin
                case (state)
                    ST_IDLE: begin
                        uart_tx  <= 1'b1;
                        baud_cnt <= '0;
                    end
                    ST_START: begin
                        if (bit_end) begin
                            state    <= ST_DATA;
                            baud_cnt <= '0;
                            uart_tx  <= shift_reg[0];
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    ST_DATA: begin
                        if (bit_end) begin
                            baud_cnt <= '0;
                            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                                state   <= ST_PARITY;
                                uart_tx <= parity_bit;
`else
                                state   <= ST_STOP;
                                uart_tx <= 1'b1;
`endif
                            end else begin
                                // shift_reg[0] is the bit on the line; [1] is next.
                                bit_cnt   <= bit_cnt + 1'b1;
                                shift_reg <= {1'b0, shift_reg[7:1]};
                                uart_tx   <= shift_reg[1];
                            end
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    ST_PARITY: begin
                        if (bit_end) begin
                            state    <= ST_STOP;
                            baud_cnt <= '0;
                            uart_tx  <= 1'b1;
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
`endif
                    ST_STOP: begin
                        if (bit_end) begin
                            state    <= ST_IDLE;
                            baud_cnt <= '0;
                            uart_tx  <= 1'b1;
                        end else begin
                            baud_cnt <= baud_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state    <= ST_IDLE;
                        baud_cnt <= '0;
                        uart_tx  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin two-requester UART transmit scheduler with byte FIFO
// Optional feature macro: UART_TX_PARITY_EN (even parity, 8E1)
// Ports: clk, rst_n; req (slave: hps/loc data, valid, ready); uart_tx line (idle high);
//        busy, fifo_level, frame_done (one-cycle pulse on last stop-bit cycle).
module uart_tx_sched
    import uart_tx_pkg::*;
#(
    parameter int CLK_HZ     = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    uart_tx_sched_if.slave              req,
    output logic                        uart_tx,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level,
    output logic                        frame_done
);

    localparam int          BAUD_DIV   = baud_div(CLK_HZ, BAUD);
    localparam int          AW         = $clog2(FIFO_DEPTH);
    localparam int          LW         = AW + 1;
    localparam logic [AW:0] LEVEL_FULL = LW'(FIFO_DEPTH);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_nxt;
    logic          last_grant;
    logic          fifo_full;
    logic          fifo_empty;
    logic          grant_hps;
    logic          grant_loc;
    logic          push_hps;
    logic          push_loc;
    logic          push;
    logic          pop;
    logic [7:0]    push_data;
    logic [7:0]    pop_data;
    logic          ser_busy_next;

    assign fifo_full  = (fifo_level == LEVEL_FULL);
    assign fifo_empty = (fifo_level == '0);

    // With both requesting, the source that did not win the last accepted transfer goes next.
    assign grant_hps = req.hps_valid && (!req.loc_valid || last_grant == SRC_LOC);
    assign grant_loc = req.loc_valid && (!req.hps_valid || last_grant == SRC_HPS);

    assign push_hps      = grant_hps && !fifo_full;
    assign push_loc      = grant_loc && !fifo_full;
    assign req.hps_ready = push_hps;
    assign req.loc_ready = push_loc;
    assign push          = push_hps || push_loc;
    assign push_data     = push_hps ? req.hps_data : req.loc_data;
    assign pop_data      = mem[rd_ptr];

    always_comb begin
        level_nxt = fifo_level;
        case ({push, pop})
            2'b10:   level_nxt = fifo_level + 1'b1;
            2'b01:   level_nxt = fifo_level - 1'b1;
            default: level_nxt = fifo_level;
        endcase
    end

    // Storage needs no reset: emptiness is tracked by the level and pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            last_grant <= SRC_LOC;
            busy       <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            fifo_level <= level_nxt;
            busy       <= ser_busy_next || (level_nxt != '0);
            if (push_hps) begin
                last_grant <= SRC_HPS;
            end else if (push_loc) begin
                last_grant <= SRC_LOC;
            end
        end
    end

    uart_tx_serializer #(
        .BAUD_DIV (BAUD_DIV)
    ) u_serializer (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_data  (pop_data),
        .fifo_pop   (pop),
        .busy_next  (ser_busy_next),
        .uart_tx    (uart_tx),
        .frame_done (frame_done)
    );

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - randomized self-checking bench for uart_tx_sched
module tb_uart_tx_sched;

    localparam int DEPTH = 8;
    localparam int DIV   = 434;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * DIV;

    // One accepted byte: edge it was accepted, edge it leaves the FIFO, payload.
    typedef struct {
        int         acc;
        int         pop;
        logic [7:0] data;
    } item_t;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       uart_tx;
    logic       busy;
    logic       frame_done;
    logic [3:0] fifo_level;

    uart_tx_sched_if bus();

    uart_tx_sched #(
        .CLK_HZ     (50000000),
        .BAUD       (115200),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (bus),
        .uart_tx    (uart_tx),
        .busy       (busy),
        .fifo_level (fifo_level),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int         n_vec    = 0;
    int         n_err    = 0;
    int         edge_n   = 0;
    int         last_pop = -1000000;
    logic       last_loc = 1'b1;
    logic [7:0] hq[$];
    logic [7:0] lq[$];
    item_t      items[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s edge=%0d got=%0h exp=%0h", tag, edge_n, got, exp);
        end
    endtask

    // Bytes accepted but not yet handed to the serialiser.
    function automatic int model_level();
        int c;
        c = 0;
        for (int i = 0; i < items.size(); i++) begin
            if (items[i].pop > edge_n) c++;
        end
        return c;
    endfunction

    // One clock: drive requesters, check ready, advance the model, check outputs.
    task automatic step();
        logic  hv, lv, eh, el, exp_tx, exp_fd, act;
        int    lvl, b;
        item_t it;
        hv = rst_n && (hq.size() > 0);
        lv = rst_n && (lq.size() > 0);
        bus.hps_valid = hv;
        bus.loc_valid = lv;
        bus.hps_data  = hv ? hq[0] : 8'h00;
        bus.loc_data  = lv ? lq[0] : 8'h00;
        lvl = model_level();
        eh  = hv && (!lv || last_loc) && (lvl < DEPTH);
        el  = lv && (!hv || !last_loc) && (lvl < DEPTH);
        #1;
        check("hps_ready", 32'(bus.hps_ready), 32'(eh));
        check("loc_ready", 32'(bus.loc_ready), 32'(el));
        @(posedge clk);
        edge_n++;
        if (!rst_n) begin
            items.delete();
            hq.delete();
            lq.delete();
            last_pop = -1000000;
            last_loc = 1'b1;
        end else if (eh || el) begin
            it.acc   = edge_n;
            it.pop   = (edge_n + 1 > last_pop + FRAME) ? edge_n + 1 : last_pop + FRAME;
            it.data  = eh ? hq.pop_front() : lq.pop_front();
            last_pop = it.pop;
            last_loc = el;
            items.push_back(it);
        end
        while (items.size() > 0 && items[0].pop + FRAME <= edge_n) void'(items.pop_front());
        @(negedge clk);
        exp_tx = 1'b1;
        exp_fd = 1'b0;
        act    = 1'b0;
        for (int i = 0; i < items.size(); i++) begin
            if (items[i].pop <= edge_n && edge_n < items[i].pop + FRAME) begin
                act = 1'b1;
                b   = (edge_n - items[i].pop) / DIV;
                if (b == 0) exp_tx = 1'b0;
                else if (b <= 8) exp_tx = items[i].data[3'(b - 1)];
`ifdef UART_TX_PARITY_EN
                else if (b == 9) exp_tx = ^items[i].data;
`endif
                else exp_tx = 1'b1;
                exp_fd = (edge_n == items[i].pop + FRAME - 1);
            end
        end
        lvl = model_level();
        check("uart_tx", 32'(uart_tx), 32'(exp_tx));
        check("frame_done", 32'(frame_done), 32'(exp_fd));
        check("fifo_level", 32'(fifo_level), 32'(lvl));
        check("busy", 32'(busy), 32'(act || (lvl > 0)));
    endtask

    task automatic drain(input int bound);
        int cnt;
        cnt = 0;
        while ((items.size() > 0 || hq.size() > 0 || lq.size() > 0) && cnt < bound) begin
            step();
            cnt++;
        end
        if (cnt >= bound) check("drain_timeout", 32'(0), 32'(1));
        repeat (5) step();
    endtask

    initial begin
        int guard;
        bus.hps_valid = 1'b0;
        bus.loc_valid = 1'b0;
        bus.hps_data  = 8'h00;
        bus.loc_data  = 8'h00;
        @(negedge clk);
        repeat (3) step();
        rst_n = 1'b1;
        repeat (5) step();

        // Contention from reset (HPS first), then FIFO saturation while a frame is on the line.
        for (int i = 0; i < 5; i++) begin
            hq.push_back(8'(32'hA0 + i));
            lq.push_back(8'(32'h50 + i));
        end
        drain(11 * FRAME);

        // Single byte into an idle block.
        hq.push_back(8'h55);
        drain(FRAME + 50);

        // One-cycle reset in the middle of data bit 3 with bytes still queued.
        hq.push_back(8'($urandom));
        lq.push_back(8'($urandom));
        hq.push_back(8'($urandom));
        guard = 0;
        while (!(items.size() > 0 && edge_n - items[0].pop == 4 * DIV + DIV / 3) && guard < 2 * FRAME) begin
            step();
            guard++;
        end
        if (guard >= 2 * FRAME) check("rst_wait_timeout", 32'(0), 32'(1));
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (20) step();

        // Randomized traffic after reset.
        for (int k = 0; k < 2; k++) begin
            repeat ($urandom_range(0, 2 * DIV)) step();
            case ($urandom_range(0, 2))
                0: hq.push_back(8'($urandom));
                1: lq.push_back(8'($urandom));
                default: begin
                    hq.push_back(8'($urandom));
                    lq.push_back(8'($urandom));
                end
            endcase
        end
        drain(6 * FRAME);

`ifdef UART_TX_PARITY_EN
        hq.push_back(8'h07);
        lq.push_back(8'h03);
        drain(3 * FRAME);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Two-requester UART transmit scheduler for the HPS-to-GPIO UART writer path. Accepts bytes from the HPS PIO source and from a local FPGA event source (debounced keys / switches) over valid/ready handshakes, arbitrates round-robin into a small FIFO, and serialises each byte as an 8N1 frame onto a GPIO pin. Sits between the soc_system PIO exports and the GPIO_0 output, clocked from FPGA_CLK1_50 and reset from hps_fpga_reset_n.

## Interface
- CLK_HZ, 50000000: input clock frequency in Hz.
- BAUD, 115200: line rate; BAUD_DIV = round(CLK_HZ/BAUD), 434 at defaults.
- FIFO_DEPTH, 8: byte FIFO depth; power of two, ≥2.

- clk  in  1  system clock, 50 MHz domain.
- rst_n  in  1  synchronous, active-low reset; one clock, sampled on rising edge of clk.
- hps_data  in  8  byte from HPS PIO requester.
- hps_valid  in  1  HPS byte valid.
- hps_ready  out  1  HPS byte accepted this cycle when high with hps_valid.
- loc_data  in  8  byte from local event requester.
- loc_valid  in  1  local byte valid.
- loc_ready  out  1  local byte accepted this cycle when high with loc_valid.
- uart_tx  out  1  serial line, idle high.
- busy  out  1  serialiser not IDLE or FIFO non-empty.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  bytes currently queued.
- frame_done  out  1  one-cycle pulse on last cycle of each stop bit.

## Operation
- Arbiter: combinational grant from valids and last_grant register. One valid: it wins. Both valid: the source not equal to last_grant wins. last_grant updates only on an accepted transfer. Reset value of last_grant = LOC, so HPS wins the first contention.
- xxx_ready = grant_xxx && !fifo_full. Requesters must not make valid depend on ready; once valid is high, data is held until accepted.
- At most one push per cycle. Push and pop in the same cycle: level unchanged. Full: both ready low, no data lost. Pointers wrap modulo FIFO_DEPTH.
- Serialiser FSM: IDLE, START, DATA, PARITY (macro only), STOP.
  - IDLE: uart_tx=1; if FIFO non-empty, pop, load shift reg, go START.
  - START: uart_tx=0 for BAUD_DIV cycles, then DATA.
  - DATA: LSB first, 8 bits, BAUD_DIV cycles each, bit counter 0..7, then PARITY or STOP.
  - STOP: uart_tx=1 for BAUD_DIV cycles; frame_done on final cycle; if FIFO non-empty, pop and go START directly (no idle gap), else IDLE.
- Baud counter counts 0..BAUD_DIV-1, reset to 0 on every state entry.
- Reset at any time, including mid-frame: next edge forces uart_tx=1, state IDLE, FIFO emptied, level 0, counters 0, busy 0, frame_done 0. A partial frame is abandoned, never completed.

## Timing
- Byte accepted at edge E into empty FIFO with serialiser IDLE: fifo_level=1 after E; pop at E+1; uart_tx low after E+1.
- Frame length: 10·BAUD_DIV cycles (11·BAUD_DIV with parity) = 4340 cycles at defaults.
- Back-to-back frames: next start bit begins the cycle after previous frame_done.
- Ready is combinational; all other outputs registered.
- Throughput into FIFO: one byte/cycle; sustained drain one byte/frame.

## Configuration
- UART_TX_PARITY_EN defined: PARITY state inserted after DATA, drives even parity (XOR of 8 data bits) for BAUD_DIV cycles; frame is 8E1, 11 bit-times.
- Undefined: no PARITY state, 8N1, 10 bit-times; no parity logic synthesised.

## Structure
- Package uart_tx_pkg: serialiser state enum, requester id constants (SRC_HPS, SRC_LOC), baud divisor function from CLK_HZ/BAUD, frame-length constants.
- Sub-module uart_tx_serializer: FSM, baud counter, bit counter, shift register; FIFO-pop/empty interface to parent. Arbiter and FIFO stay in uart_tx_sched.

## Test plan
- Single HPS byte 0x55 into idle block -> uart_tx low one cycle after accept, bits 1,0,1,0,1,0,1,0 each 434 cycles, stop high, frame_done once at cycle 4340 of frame.
- hps_valid and loc_valid held high with distinct streams (0xA0.., 0x50..) -> accepts alternate HPS, LOC, HPS, …; first accepted is HPS; serial output order matches acceptance order.
- Push 9 bytes while serialiser holds the line (DEPTH 8) -> fifo_level saturates at 8, ready low on the overflow byte until first pop; all 9 bytes emitted contiguously with no idle gap.
- rst_n asserted one cycle mid DATA bit 3 -> next edge uart_tx=1, fifo_level=0, busy=0; queued bytes never transmitted; new byte after reset produces a clean frame.
- With UART_TX_PARITY_EN, send 0x07 -> parity bit 1, frame 4774 cycles; send 0x03 -> parity bit 0.
